// File: rtl/conv_argmax_out.sv
// Argmax output stage for the convolution chain: tracks the running maximum of each
// LEN-element vector and presents value/index through a one-entry output register.
module conv_argmax_out #(
  parameter int T     = 8,
  parameter int LEN   = 2,
  parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [T-1:0]  s_data_in,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [T-1:0]  m_data_out,
  output logic [IDX_W-1:0]     m_index,
  output logic                 m_valid,
  input  logic                 m_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

  state_t                state;
  state_t                state_next;
  logic [IDX_W-1:0]      cnt;
  logic signed [T-1:0]   best;
  logic [IDX_W-1:0]      best_idx;
  logic signed [T-1:0]   cand_val;
  logic [IDX_W-1:0]      cand_idx;
  logic                  last;
  logic                  accept;
  logic                  complete;

  assign last = (cnt == LAST);

  // Element 0 always seeds the running max; later elements win only when strictly greater.
  always_comb begin
    cand_val = best;
    cand_idx = best_idx;
    if (cnt == '0 || s_data_in > best) begin
      cand_val = s_data_in;
      cand_idx = cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Only the completing element stalls, and only while an unread result is held.
  always_comb begin
    m_valid    = (state == FULL);
    s_ready    = !(m_valid && !m_ready && last);
    accept     = s_valid && s_ready;
    complete   = accept && last;
    state_next = state;
    case (state)
      EMPTY: if (complete) state_next = FULL;
      FULL:  if (!complete && m_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      best       <= '0;
      best_idx   <= '0;
      m_data_out <= '0;
      m_index    <= '0;
    end else if (accept) begin
      best     <= cand_val;
      best_idx <= cand_idx;
      cnt      <= last ? '0 : cnt + IDX_W'(1);
      if (complete) begin
        m_data_out <= cand_val;
        m_index    <= cand_idx;
      end
    end
  end

endmodule

// File: tb/tb_conv_argmax_out.sv
// Directed scoreboard bench for conv_argmax_out with a LEN=2 and a LEN=1 instance.
module tb_conv_argmax_out;

  typedef struct {
    int val;
    int idx;
  } result_t;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] s_data_in;
  logic              s_valid;
  logic              s_ready;
  logic signed [7:0] m_data_out;
  logic [0:0]        m_index;
  logic              m_valid;
  logic              m_ready;

  logic signed [7:0] s1_data;
  logic              s1_valid;
  logic              s1_ready;
  logic signed [7:0] m1_data;
  logic [0:0]        m1_index;
  logic              m1_valid;
  logic              m1_ready;

  result_t exp_q[$];
  result_t exp1_q[$];
  int      check_count = 0;
  int      pass_count  = 0;

  conv_argmax_out #(.T(8), .LEN(2)) dut (
    .clk(clk), .reset(reset), .s_data_in(s_data_in), .s_valid(s_valid), .s_ready(s_ready),
    .m_data_out(m_data_out), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready)
  );

  conv_argmax_out #(.T(8), .LEN(1)) dut1 (
    .clk(clk), .reset(reset), .s_data_in(s1_data), .s_valid(s1_valid), .s_ready(s1_ready),
    .m_data_out(m1_data), .m_index(m1_index), .m_valid(m1_valid), .m_ready(m1_ready)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Pop and compare whenever a result is handed over downstream.
  task automatic watch();
    result_t e;
    if (m_valid && m_ready) begin
      check_output("sb_has_entry", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("sb_val", $signed(m_data_out), e.val);
        check_output("sb_idx", 32'(m_index), e.idx);
      end
    end
    if (m1_valid && m1_ready) begin
      check_output("sb1_has_entry", 32'(exp1_q.size() > 0), 1);
      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        check_output("sb1_val", $signed(m1_data), e.val);
        check_output("sb1_idx", 32'(m1_index), e.idx);
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    watch();
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int v, input int i);
    result_t e;
    e.val = v;
    e.idx = i;
    exp_q.push_back(e);
  endtask

  // Two-element vector with m_ready high; result must appear exactly one cycle later.
  task automatic apply_stimulus(input int a, input int b, input int ev, input int ei);
    push_exp(ev, ei);
    s_valid   = 1'b1;
    s_data_in = 8'(a);
    half();
    check_output("s_ready_e0", 32'(s_ready), 1);
    edge_step();
    s_data_in = 8'(b);
    half();
    check_output("s_ready_e1", 32'(s_ready), 1);
    edge_step();
    s_valid = 1'b0;
    half();
    check_output("latency_valid", 32'(m_valid), 1);
    edge_step();
    half();
    check_output("valid_drops", 32'(m_valid), 0);
    edge_step();
  endtask

  initial begin
    int    vals1[3];
    int    stream[6];
    result_t e1;
    reset     = 1'b0;
    s_data_in = '0;
    s_valid   = 1'b0;
    m_ready   = 1'b1;
    s1_data   = '0;
    s1_valid  = 1'b0;
    m1_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid", 32'(m_valid), 0);
    check_output("rst_data", $signed(m_data_out), 0);
    check_output("rst_index", 32'(m_index), 0);
    check_output("rst1_valid", 32'(m1_valid), 0);
    reset = 1'b1;
    edge_step();

    $display("[TB] basic vectors");
    apply_stimulus(5, -3, 5, 0);
    apply_stimulus(-7, -2, -2, 1);
    apply_stimulus(4, 4, 4, 0);

    $display("[TB] backpressure");
    m_ready = 1'b0;
    push_exp(9, 1);
    push_exp(2, 1);
    s_valid   = 1'b1;
    s_data_in = 8'sd3;
    half();
    edge_step();
    s_data_in = 8'sd9;
    half();
    edge_step();
    s_data_in = 8'sd1;
    half();
    check_output("bp_valid", 32'(m_valid), 1);
    check_output("bp_ready_e0", 32'(s_ready), 1);
    edge_step();
    s_data_in = 8'sd2;
    half();
    check_output("bp_stall", 32'(s_ready), 0);
    check_output("bp_hold_val", $signed(m_data_out), 9);
    check_output("bp_hold_idx", 32'(m_index), 1);
    edge_step();
    half();
    check_output("bp_stall2", 32'(s_ready), 0);
    check_output("bp_hold_val2", $signed(m_data_out), 9);
    edge_step();
    m_ready = 1'b1;
    half();
    check_output("bp_release", 32'(s_ready), 1);
    edge_step();
    s_valid = 1'b0;
    half();
    check_output("bp_reload_valid", 32'(m_valid), 1);
    check_output("bp_reload_val", $signed(m_data_out), 2);
    check_output("bp_reload_idx", 32'(m_index), 1);
    edge_step();
    half();
    check_output("bp_empty", 32'(m_valid), 0);
    edge_step();

    $display("[TB] back-to-back");
    stream = '{3, 8, -1, -5, 127, -128};
    push_exp(8, 1);
    push_exp(-1, 0);
    push_exp(127, 0);
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data_in = 8'(stream[i]);
      half();
      check_output("b2b_ready", 32'(s_ready), 1);
      edge_step();
    end
    s_valid = 1'b0;
    repeat (2) begin
      half();
      edge_step();
    end
    check_output("b2b_drained", exp_q.size(), 0);

    $display("[TB] async reset");
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_data_in = 8'sd20;
    half();
    edge_step();
    s_data_in = 8'sd30;
    half();
    edge_step();
    s_data_in = 8'sd6;
    half();
    check_output("ar_pre_valid", 32'(m_valid), 1);
    edge_step();
    s_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_output("ar_valid", 32'(m_valid), 0);
    check_output("ar_data", $signed(m_data_out), 0);
    check_output("ar_index", 32'(m_index), 0);
    edge_step();
    reset   = 1'b1;
    m_ready = 1'b1;
    edge_step();
    apply_stimulus(6, 10, 10, 1);

    $display("[TB] LEN=1 instance");
    vals1 = '{-4, 7, 0};
    s1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e1.val = vals1[i];
      e1.idx = 0;
      exp1_q.push_back(e1);
      s1_data = 8'(vals1[i]);
      half();
      check_output("l1_ready", 32'(s1_ready), 1);
      if (i > 0) begin
        check_output("l1_valid", 32'(m1_valid), 1);
        check_output("l1_val", $signed(m1_data), vals1[i-1]);
      end
      edge_step();
    end
    s1_valid = 1'b0;
    half();
    check_output("l1_last_valid", 32'(m1_valid), 1);
    check_output("l1_last_val", $signed(m1_data), 0);
    edge_step();
    half();
    check_output("l1_empty", 32'(m1_valid), 0);
    check_output("sb_left", exp_q.size(), 0);
    check_output("sb1_left", exp1_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/conv_argmax_out.md
Name: conv_argmax_out

Overview:
- Output stage placed directly downstream of the three-layer convolution chain (layer1 → layer2 → layer3).
- Consumes the final layer's stream of LEN signed T-bit results per input vector.
- Emits one result per vector: the maximum value and its index.
- Uses the same valid/ready streaming handshake as the convolution layers, so it bolts onto the last layer's master port unchanged.

Parameters:
- T, 8: data width in bits; signed two's complement.
- LEN, 2: number of results per vector (final layer output length). Legal range ≥1.
- IDX_W, max(1, clog2(LEN)): width of the index output.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- s_data_in, input, T: signed result from the upstream layer.
- s_valid, input, 1: s_data_in is valid.
- s_ready, output, 1: block accepts s_data_in this cycle.
- m_data_out, output, T: maximum value of the completed vector.
- m_index, output, IDX_W: position (0..LEN-1) of that maximum within the vector.
- m_valid, output, 1: m_data_out and m_index hold a completed result.
- m_ready, input, 1: downstream consumes the result this cycle.

Behaviour:
- Reset (reset low, asynchronous):
  - m_valid=0, m_data_out=0, m_index=0.
  - Internal element counter cnt=0, best value=0, best index=0.
  - Reset asserted mid-vector discards the partial vector and any undelivered result. After release, the next accepted element is treated as element 0.
- Accept: an element is accepted in a cycle where s_valid & s_ready.
- Collect (driven by cnt, 0..LEN-1):
  - cnt==0 accept: best←s_data_in, best index←0.
  - cnt>0 accept: if s_data_in > best (signed, strictly greater), best←s_data_in, best index←cnt. Ties keep the earlier (lower) index.
  - cnt increments on each accept and wraps to 0 after the LEN-th element.
- Completion (accept with cnt==LEN-1):
  - The final compare is included.
  - m_data_out/m_index load the winning value/index.
  - m_valid=1 from the next cycle.
  - Latency: 1 cycle from the final accept edge to m_valid high.
- Output register is one entry; states EMPTY (m_valid=0) and FULL (m_valid=1).
  - FULL→EMPTY when m_ready=1 and there is no simultaneous completion.
  - Completion in the same cycle as m_valid & m_ready: register reloads with the new result and m_valid stays 1. No bubble and no lost result.
  - While FULL and m_ready=0, m_data_out/m_index hold stable.
- Backpressure:
  - s_ready = !(m_valid & !m_ready & cnt==LEN-1). Only the completing element stalls; elements 0..LEN-2 of the next vector are accepted while a result waits.
  - s_ready depends combinationally on m_ready; this is the only combinational input-to-output path.
- Widths: no arithmetic growth. Compare is a signed T-bit compare; outputs pass the value through unmodified.
- LEN==1: every accepted element completes a vector, m_index is always 0, and the block behaves as a 1-deep registered pipe with the same handshake.
- s_data_in is ignored when s_valid=0. Inputs offered while s_ready=0 are not consumed, and cnt/best are unchanged.

Test Plan:
- Reset then stream LEN=2 values {5, -3}, m_ready=1 → one cycle after the 2nd accept: m_valid=1, m_data_out=5, m_index=0; m_valid=0 the following cycle.
- Values {-7, -2} → m_data_out=-2, m_index=1 (signed compare). Values {4, 4} → m_data_out=4, m_index=0 (tie keeps the lower index).
- Hold m_ready=0 after result {9, idx 1}, then offer the next vector {1, 2} → element 1 accepted, s_ready=0 on element 2, output holds 9/1. Raise m_ready → same cycle s_ready=1, element 2 accepted, next cycle m_data_out=2, m_index=1, m_valid=1.
- Back-to-back vectors {3,8},{-1,-5},{127,-128} with s_valid and m_ready held high → results 8/1, -1/0, 127/0 on consecutive completions, with no dropped or duplicated m_valid pulses.
- Assert reset low asynchronously (between edges) after the first element of a vector and while m_valid=1 → outputs go to 0 immediately. After release, the vector {6, 10} yields 10/1.
- LEN=1 instance: stream {-4, 7, 0} with m_ready=1 → outputs -4, 7, 0 each with m_index=0, each 1 cycle after its accept.
